// File: rtl/word_unpacker_if.sv
// Block-in / word-out handshake bundle for word_unpacker.
// Slave is the unpacker side; master is the producer/consumer side.
interface word_unpacker_if #(
  parameter int WORD_W  = 32,
  parameter int N_WORDS = 4
);
  localparam int BLK_W = WORD_W * N_WORDS;
  localparam int IDX_W = $clog2(N_WORDS);

  logic             valid_i;
  logic             ready_o;
  logic [BLK_W-1:0] block_i;
  logic [IDX_W-1:0] nwords_i;
  logic             last_i;
  logic             valid_o;
  logic             ready_i;
  logic [WORD_W-1:0] word_o;
  logic             last_o;

  modport slave (
    input  valid_i, block_i, nwords_i, last_i,
    input  ready_i,
    output ready_o,
    output valid_o, word_o, last_o
  );

  modport master (
    output valid_i, block_i, nwords_i, last_i,
    output ready_i,
    input  ready_o,
    input  valid_o, word_o, last_o
  );
endinterface

// File: rtl/word_unpacker.sv
// Two-entry block buffer that drains 128-bit blocks
// as a stream of 32-bit words, LSB word first.
module word_unpacker #(
  parameter int WORD_W  = 32,
  parameter int N_WORDS = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clr_i,
  input  logic            enable_i,
  word_unpacker_if.slave  bus
);
  localparam int BLK_W = WORD_W * N_WORDS;
  localparam int IDX_W = $clog2(N_WORDS);

  typedef enum logic [1:0] {
    EMPTY,
    ACTIVE,
    FULL
  } state_e;

  typedef struct packed {
    logic [BLK_W-1:0] blk;
    logic [IDX_W-1:0] n;
    logic             last;
  } entry_t;

  state_e           state_q, state_d;
  entry_t           act_q, act_d;
  entry_t           pend_q, pend_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  entry_t in_ent;
  logic   ready;
  logic   valid;
  logic   in_fire;
  logic   out_fire;
  logic   at_end;
  logic   done;

  assign in_ent   = {bus.block_i, bus.nwords_i, bus.last_i};
  assign ready    = enable_i & ~rst_i & (state_q != FULL);
  assign valid    = enable_i & (state_q != EMPTY);
  assign in_fire  = bus.valid_i & ready;
  assign out_fire = valid & bus.ready_i;
  // n=0 encodes a full block, so n-1 wraps to the top index
  assign at_end   = (idx_q == act_q.n - IDX_W'(1));
  assign done     = out_fire & at_end;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      state_q <= EMPTY;
      act_q   <= '0;
      pend_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      pend_q  <= pend_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    act_d   = act_q;
    pend_d  = pend_q;
    idx_d   = idx_q;
    if (out_fire)
      idx_d = idx_q + IDX_W'(1);
    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d = ACTIVE;
          act_d   = in_ent;
          idx_d   = '0;
        end
      end
      ACTIVE: begin
        if (done && in_fire) begin
          act_d = in_ent;
          idx_d = '0;
        end else if (done) begin
          state_d = EMPTY;
        end else if (in_fire) begin
          state_d = FULL;
          pend_d  = in_ent;
        end
      end
      FULL: begin
        if (done) begin
          state_d = ACTIVE;
          act_d   = pend_q;
          idx_d   = '0;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    bus.ready_o = ready;
    bus.valid_o = valid;
    bus.word_o  = act_q.blk[idx_q*WORD_W +: WORD_W];
    bus.last_o  = (state_q != EMPTY) & act_q.last & at_end;
  end
endmodule

// File: tb/tb_word_unpacker.sv
// Directed bench for word_unpacker.
// Drives on the falling edge and checks 1 ns later.
module tb_word_unpacker;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  logic en  = 1'b1;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  word_unpacker_if #(.WORD_W(32), .N_WORDS(4)) bus();

  word_unpacker #(
    .WORD_W(32),
    .N_WORDS(4)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .clr_i(clr),
    .enable_i(en),
    .bus(bus)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // ctl = {rst, clr, enable}
  task automatic drv(
    input logic         v,
    input logic [127:0] b,
    input logic [1:0]   n,
    input logic         l,
    input logic         r,
    input logic [2:0]   ctl = 3'b001
  );
    @(negedge clk);
    rst          = ctl[2];
    clr          = ctl[1];
    en           = ctl[0];
    bus.valid_i  = v;
    bus.block_i  = b;
    bus.nwords_i = n;
    bus.last_i   = l;
    bus.ready_i  = r;
    #1;
  endtask

  task automatic expo(
    input string       tag,
    input logic        v,
    input logic [31:0] w,
    input logic        la
  );
    chk({tag, ".v"}, 32'(bus.valid_o), 32'(v));
    if (v)
      chk({tag, ".w"}, bus.word_o, w);
    chk({tag, ".l"}, 32'(bus.last_o), 32'(la));
  endtask

  task automatic rdy(input string tag, input logic e);
    chk({tag, ".rdy"}, 32'(bus.ready_o), 32'(e));
  endtask

  function automatic logic [127:0] mk(input int b);
    logic [127:0] x;
    for (int k = 0; k < 4; k++)
      x[32*k +: 32] = {16'hB0B0, 8'(b), 8'(k)};
    return x;
  endfunction

  localparam logic [127:0] B1 =
    128'h55555555_12345678_BBBBBBBB_AAAAAAAA;
  localparam logic [127:0] P0 =
    128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
  localparam logic [127:0] P1 =
    128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] Q0 =
    128'h1000FFFF_10000002_10000001_10000000;
  localparam logic [127:0] Q1 =
    128'h2FFFFFFF_2FFFFFFF_2FFFFFFF_20000000;
  localparam logic [127:0] E0 =
    128'hE3E3E3E3_E2E2E2E2_E1E1E1E1_E0E0E0E0;
  localparam logic [127:0] C0 =
    128'hC3C3C3C3_C2C2C2C2_C1C1C1C1_C0C0C0C0;
  localparam logic [127:0] C1 =
    128'hC7C7C7C7_C6C6C6C6_C5C5C5C5_C4C4C4C4;
  localparam logic [127:0] N0 =
    128'h9FFFFFFF_9FFFFFFF_90000001_90000000;
  localparam logic [127:0] R2 =
    128'h73737373_72727272_71717171_70707070;

  initial begin
    logic [0:13] rdy2;
    logic [31:0] bp [8];
    int sent;

    bus.valid_i  = 1'b0;
    bus.block_i  = '0;
    bus.nwords_i = '0;
    bus.last_i   = 1'b0;
    bus.ready_i  = 1'b0;

    // reset state
    drv(0, '0, 0, 0, 0, 3'b101);
    drv(0, '0, 0, 0, 0, 3'b101);
    rdy("rst", 0);
    expo("rst", 0, 0, 0);
    chk("rst.w", bus.word_o, 32'h0);
    drv(0, '0, 0, 0, 0);
    rdy("rst.rel", 1);

    // single block
    drv(1, B1, 0, 0, 1);
    rdy("sb", 1);
    drv(0, '0, 0, 0, 1);
    expo("sb0", 1, 32'hAAAAAAAA, 0);
    drv(0, '0, 0, 0, 1);
    expo("sb1", 1, 32'hBBBBBBBB, 0);
    drv(0, '0, 0, 0, 1);
    expo("sb2", 1, 32'h12345678, 0);
    drv(0, '0, 0, 0, 1);
    expo("sb3", 1, 32'h55555555, 0);
    drv(0, '0, 0, 0, 1);
    expo("sb.end", 0, 0, 0);

    // back-to-back full blocks
    rdy2 = 14'b11000100011111;
    sent = 0;
    for (int c = 0; c < 14; c++) begin
      drv(sent < 3, mk(sent), 0, 0, 1);
      rdy("b2b", rdy2[c]);
      expo("b2b", (c >= 1 && c <= 12),
           {16'hB0B0, 8'((c - 1) / 4), 8'((c - 1) % 4)},
           0);
      if (bus.valid_i && bus.ready_o)
        sent++;
    end

    // backpressure
    drv(1, P0, 0, 0, 0);
    rdy("bp.a", 1);
    drv(1, P1, 0, 0, 0);
    rdy("bp.b", 1);
    expo("bp.b", 1, 32'hAAAAAAAA, 0);
    drv(0, '0, 0, 0, 0);
    rdy("bp.c", 0);
    expo("bp.c", 1, 32'hAAAAAAAA, 0);
    drv(0, '0, 0, 0, 0);
    rdy("bp.d", 0);
    expo("bp.d", 1, 32'hAAAAAAAA, 0);
    bp = '{32'hAAAAAAAA, 32'hBBBBBBBB,
           32'hCCCCCCCC, 32'hDDDDDDDD,
           32'h11111111, 32'h22222222,
           32'h33333333, 32'h44444444};
    for (int i = 0; i < 8; i++) begin
      drv(0, '0, 0, 0, 1);
      rdy("bp.dr", i >= 4);
      expo("bp.dr", 1, bp[i], 0);
    end
    drv(0, '0, 0, 0, 1);
    expo("bp.end", 0, 0, 0);

    // partial block with last, then 1-word block
    drv(1, Q0, 3, 1, 1);
    drv(1, Q1, 1, 0, 1);
    rdy("pl", 1);
    expo("pl0", 1, 32'h10000000, 0);
    drv(0, '0, 0, 0, 1);
    expo("pl1", 1, 32'h10000001, 0);
    drv(0, '0, 0, 0, 1);
    expo("pl2", 1, 32'h10000002, 1);
    drv(0, '0, 0, 0, 1);
    expo("pl3", 1, 32'h20000000, 0);
    drv(0, '0, 0, 0, 1);
    expo("pl.end", 0, 0, 0);

    // enable pause
    drv(1, E0, 0, 0, 1);
    drv(0, '0, 0, 0, 1);
    expo("en0", 1, 32'hE0E0E0E0, 0);
    drv(0, '0, 0, 0, 1);
    expo("en1", 1, 32'hE1E1E1E1, 0);
    drv(0, '0, 0, 0, 1, 3'b000);
    expo("en.off", 0, 0, 0);
    rdy("en.off", 0);
    drv(0, '0, 0, 0, 1, 3'b000);
    expo("en.off2", 0, 0, 0);
    rdy("en.off2", 0);
    drv(0, '0, 0, 0, 1);
    expo("en2", 1, 32'hE2E2E2E2, 0);
    drv(0, '0, 0, 0, 1);
    expo("en3", 1, 32'hE3E3E3E3, 0);
    drv(0, '0, 0, 0, 1);
    expo("en.end", 0, 0, 0);

    // clear with a pending block
    drv(1, C0, 0, 0, 0);
    drv(1, C1, 0, 0, 0);
    drv(0, '0, 0, 0, 1);
    rdy("clr.full", 0);
    expo("clr.pre", 1, 32'hC0C0C0C0, 0);
    drv(0, '0, 0, 0, 1, 3'b011);
    drv(0, '0, 0, 0, 1);
    expo("clr.post", 0, 0, 0);
    chk("clr.w", bus.word_o, 32'h0);
    rdy("clr.post", 1);
    for (int i = 0; i < 3; i++) begin
      drv(0, '0, 0, 0, 1);
      expo("clr.idle", 0, 0, 0);
    end
    drv(1, N0, 2, 0, 1);
    drv(0, '0, 0, 0, 1);
    expo("clr.n0", 1, 32'h90000000, 0);
    drv(0, '0, 0, 0, 1);
    expo("clr.n1", 1, 32'h90000001, 0);
    drv(0, '0, 0, 0, 1);
    expo("clr.end", 0, 0, 0);

    // reset while full
    drv(1, C0, 0, 0, 0);
    drv(1, C1, 0, 0, 0);
    drv(0, '0, 0, 0, 0, 3'b101);
    rdy("mrst.hi", 0);
    drv(0, '0, 0, 0, 1);
    expo("mrst", 0, 0, 0);
    chk("mrst.w", bus.word_o, 32'h0);
    rdy("mrst", 1);
    drv(1, R2, 0, 0, 1);
    drv(0, '0, 0, 0, 1);
    expo("mrst0", 1, 32'h70707070, 0);
    drv(0, '0, 0, 0, 1);
    expo("mrst1", 1, 32'h71717171, 0);
    drv(0, '0, 0, 0, 1);
    expo("mrst2", 1, 32'h72727272, 0);
    drv(0, '0, 0, 0, 1);
    expo("mrst3", 1, 32'h73737373, 0);
    drv(0, '0, 0, 0, 1);
    expo("mrst.end", 0, 0, 0);

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end
endmodule
